// File: rtl/obstacle_scroller.sv
// ---------------------------------------------------------------------------
// obstacle_scroller
//
// Frame-synchronous motion and collision controller for the VGA game.
// It drives LANES independently scrolling obstacle lanes. Each lane has a
// wrap-around x offset that advances once per frame. The block also runs an
// IDLE / RUN / HIT play state machine and keeps a saturating pass score,
// which counts how many times lane 0 has wrapped.
//
// Optional feature macro: OBSTACLE_SCROLLER_SPEEDUP_EN
//   When defined, the per-frame step is speed + score[7:3], clamped to the
//   largest value that fits in SPEED_W bits, so the game speeds up by
//   1 px/frame for every 8 points scored. When undefined, the step is speed
//   unchanged.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   frame_tick   one-cycle pulse at the start of vertical blank
//   start        level; begins play from IDLE or restarts play from HIT
//   speed        pixels advanced per frame
//   player_px    player draw flag for the current pixel
//   obstacle_px  per-lane obstacle draw flag for the current pixel
//   x_offset     packed lane offsets; lane i occupies [i*XW +: XW]
//   state        0 = IDLE, 1 = RUN, 2 = HIT
//   hit          one-cycle pulse on entry to HIT
//   score        lane-0 wrap count, saturating at 255
// ---------------------------------------------------------------------------
module obstacle_scroller #(
  parameter int LANES        = 2,
  parameter int XW           = 10,
  parameter int SCREEN_W     = 640,
  parameter int SPEED_W      = 4,
  parameter int LANE_STAGGER = 320
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic [SPEED_W-1:0]    speed,
  input  logic                  player_px,
  input  logic [LANES-1:0]      obstacle_px,
  output logic [LANES*XW-1:0]   x_offset,
  output logic [1:0]            state,
  output logic                  hit,
  output logic [7:0]            score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  localparam logic [XW:0] SCREEN_V = (XW+1)'(SCREEN_W);

  state_t             state_q, state_d;
  logic [XW-1:0]      off_q [LANES];
  logic [XW-1:0]      off_d [LANES];
  logic [XW:0]        sum   [LANES];
  logic [XW:0]        diff  [LANES];
  logic [XW-1:0]      adv   [LANES];
  logic [LANES-1:0]   wrap;
  logic [7:0]         score_q, score_d;
  logic               hit_q, hit_d;
  logic               collision;
  logic [SPEED_W-1:0] eff_speed;

  // Starting position of a lane. The lanes are staggered so that they do not
  // all arrive on screen at the same moment.
  function automatic logic [XW-1:0] reset_offset(input int lane);
    return XW'((lane * LANE_STAGGER) % SCREEN_W);
  endfunction

  // A collision is only counted while the game is running. This keeps a
  // stray overlap in IDLE or HIT from retriggering the hit pulse.
  assign collision = (state_q == ST_RUN) && player_px && (|obstacle_px);

`ifdef OBSTACLE_SCROLLER_SPEEDUP_EN
  // Add the score bonus in a wide adder so the sum cannot overflow, then
  // clamp the result to the largest step the speed field can express.
  localparam int BOOST_W = SPEED_W + 6;
  localparam logic [BOOST_W-1:0] SPEED_MAX = BOOST_W'((1 << SPEED_W) - 1);
  logic [BOOST_W-1:0] boosted;

  always_comb begin
    boosted   = BOOST_W'(speed) + BOOST_W'(score_q[7:3]);
    eff_speed = (boosted > SPEED_MAX) ? {SPEED_W{1'b1}} : boosted[SPEED_W-1:0];
  end
`else
  assign eff_speed = speed;
`endif

  // Work out each lane's next position modulo the screen width. The step is
  // always smaller than the screen, so one conditional subtract is enough to
  // wrap. wrap[0] also drives the score.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum[i]  = {1'b0, off_q[i]} + {{(XW+1-SPEED_W){1'b0}}, eff_speed};
      wrap[i] = (sum[i] >= SCREEN_V);
      diff[i] = sum[i] - SCREEN_V;
      adv[i]  = wrap[i] ? diff[i][XW-1:0] : sum[i][XW-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. The default branch catches the unused encoding and
  // returns the machine to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start     ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = collision ? ST_HIT : ST_RUN;
      ST_HIT:  state_d = start     ? ST_RUN : ST_HIT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic. IDLE keeps the lanes parked at their starting
  // positions, so leaving IDLE needs no explicit reload. In RUN a collision
  // has priority over frame_tick: the offsets freeze at the exact frame
  // where the player was hit. Restarting from HIT reloads the starting
  // positions and clears the score.
  always_comb begin
    off_d   = off_q;
    score_d = score_q;
    hit_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < LANES; i++) off_d[i] = reset_offset(i);
        score_d = 8'd0;
      end
      ST_RUN: begin
        if (collision) begin
          hit_d = 1'b1;
        end else if (frame_tick) begin
          for (int i = 0; i < LANES; i++) off_d[i] = adv[i];
          if (wrap[0] && (score_q != 8'hFF)) score_d = score_q + 8'd1;
        end
      end
      ST_HIT: begin
        if (start) begin
          for (int i = 0; i < LANES; i++) off_d[i] = reset_offset(i);
          score_d = 8'd0;
        end
      end
      default: begin
        for (int i = 0; i < LANES; i++) off_d[i] = reset_offset(i);
        score_d = 8'd0;
      end
    endcase
  end

  // Datapath registers. Every output comes from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) off_q[i] <= reset_offset(i);
      score_q <= 8'd0;
      hit_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) off_q[i] <= off_d[i];
      score_q <= score_d;
      hit_q   <= hit_d;
    end
  end

  // Pack the lane offsets into the flat bus that the renderers expect.
  always_comb begin
    x_offset = '0;
    for (int i = 0; i < LANES; i++) x_offset[i*XW +: XW] = off_q[i];
  end

  assign state = state_q;
  assign hit   = hit_q;
  assign score = score_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// ---------------------------------------------------------------------------
// tb_obstacle_scroller
//
// Testbench for obstacle_scroller. A behavioural game model tracks the
// expected state, lane offsets, score and hit pulse using plain modular
// arithmetic. A compare process checks the DUT against this model on every
// falling clock edge. Directed phases pin the model to hand-computed
// values, and a randomized phase then exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_obstacle_scroller;

  localparam int LANES    = 2;
  localparam int XW       = 10;
  localparam int SCREEN_W = 640;
  localparam int SPEED_W  = 4;
  localparam int STAGGER  = 320;

  logic                clk = 1'b0;
  logic                rst;
  logic                frame_tick;
  logic                start;
  logic [SPEED_W-1:0]  speed;
  logic                player_px;
  logic [LANES-1:0]    obstacle_px;
  logic [LANES*XW-1:0] x_offset;
  logic [1:0]          state;
  logic                hit;
  logic [7:0]          score;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: 0 idle, 1 running, 2 hit.
  int m_state;
  int m_off [LANES];
  int m_score;
  int m_hit;

  obstacle_scroller #(
    .LANES(LANES), .XW(XW), .SCREEN_W(SCREEN_W),
    .SPEED_W(SPEED_W), .LANE_STAGGER(STAGGER)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .speed(speed), .player_px(player_px), .obstacle_px(obstacle_px),
    .x_offset(x_offset), .state(state), .hit(hit), .score(score)
  );

  always #5 clk = ~clk;

  function automatic int lane(input int i);
    return int'(x_offset[i*XW +: XW]);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Put the model back at its power-on values.
  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_hit   = 0;
    for (int i = 0; i < LANES; i++) m_off[i] = (i * STAGGER) % SCREEN_W;
  endtask

  function automatic int model_eff(input int spd);
`ifdef OBSTACLE_SCROLLER_SPEEDUP_EN
    int s;
    s = spd + m_score / 8;
    return (s > 15) ? 15 : s;
`else
    return spd;
`endif
  endfunction

  // Apply the game rules for one clock edge, given the inputs present at
  // that edge.
  task automatic model_step(input bit ft, input bit st, input int spd,
                            input bit ppx, input int opx);
    int e;
    m_hit = 0;
    case (m_state)
      0: if (st) begin
           model_reset();
           m_state = 1;
         end
      1: if (ppx && opx != 0) begin
           m_state = 2;
           m_hit   = 1;
         end else if (ft) begin
           e = model_eff(spd);
           if (m_off[0] + e >= SCREEN_W && m_score < 255) m_score++;
           for (int i = 0; i < LANES; i++) m_off[i] = (m_off[i] + e) % SCREEN_W;
         end
      default: if (st) begin
           model_reset();
           m_state = 1;
         end
    endcase
  endtask

  // Drive one cycle of inputs, let the edge pass, then update the model.
  // The task returns 1 time unit after the rising edge.
  task automatic applyStimulus(input bit ft, input bit st, input int spd,
                               input bit ppx, input int opx);
    frame_tick  = ft;
    start       = st;
    speed       = spd[SPEED_W-1:0];
    player_px   = ppx;
    obstacle_px = opx[LANES-1:0];
    @(posedge clk);
    if (!rst) model_step(ft, st, spd, ppx, opx);
    #1;
    frame_tick  = 1'b0;
    start       = 1'b0;
    player_px   = 1'b0;
    obstacle_px = '0;
  endtask

  task automatic ticks(input int n, input int spd);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, spd, 1'b0, 0);
  endtask

  // Compare process: check every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("state", int'(state), m_state);
    checkOutput("hit", int'(hit), m_hit);
    checkOutput("score", int'(score), m_score);
    for (int i = 0; i < LANES; i++)
      checkOutput($sformatf("lane%0d", i), lane(i), m_off[i]);
  end

  initial begin
    int prev;
    int guard;

    rst = 1'b1;
    frame_tick = 1'b0; start = 1'b0; speed = '0;
    player_px = 1'b0; obstacle_px = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_lane0", lane(0), 0);
    checkOutput("rst_lane1", lane(1), 320);
    checkOutput("rst_score", int'(score), 0);
    rst = 1'b0;

    // Start the game.
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    checkOutput("start_state", int'(state), 1);

    // Scroll and wrap.
    ticks(127, 5);
    checkOutput("tick127_lane0", lane(0), 635);
    checkOutput("tick127_score", int'(score), 0);
    ticks(1, 5);
    checkOutput("tick128_lane0", lane(0), 0);
    checkOutput("tick128_lane1", lane(1), 320);
    checkOutput("tick128_score", int'(score), 1);

    // Speed zero holds the lanes in place.
    ticks(10, 0);
    checkOutput("spd0_lane0", lane(0), 0);
    checkOutput("spd0_lane1", lane(1), 320);
    checkOutput("spd0_score", int'(score), 1);

    // Collision.
    ticks(3, 7);
    prev = lane(0);
    applyStimulus(1'b0, 1'b0, 7, 1'b1, 2);
    checkOutput("coll_hit", int'(hit), 1);
    checkOutput("coll_state", int'(state), 2);
    applyStimulus(1'b0, 1'b0, 7, 1'b0, 0);
    checkOutput("coll_hit_drop", int'(hit), 0);
    ticks(5, 7);
    checkOutput("coll_frozen", lane(0), prev);
    checkOutput("coll_frozen_lit", lane(0), 21);

    // A collision and a frame_tick arrive together.
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    checkOutput("restart1_lane0", lane(0), 0);
    checkOutput("restart1_state", int'(state), 1);
    ticks(25, 4);
    checkOutput("simul_pre_lane0", lane(0), 100);
    applyStimulus(1'b1, 1'b0, 4, 1'b1, 1);
    checkOutput("simul_lane0", lane(0), 100);
    checkOutput("simul_state", int'(state), 2);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    checkOutput("restart_lane0", lane(0), 0);
    checkOutput("restart_lane1", lane(1), 320);
    checkOutput("restart_score", int'(score), 0);
    checkOutput("restart_state", int'(state), 1);

    // Reset in the middle of a run.
    ticks(100, 4);
    checkOutput("midrun_lane0", lane(0), 400);
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("midrst_lane0", lane(0), 0);
    checkOutput("midrst_state", int'(state), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 9, 1'b0, 0);
    checkOutput("post_rst_idle", int'(state), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 3)));
    end

`ifdef OBSTACLE_SCROLLER_SPEEDUP_EN
    // Speedup: play until the score reaches 8, then check the per-frame step.
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    guard = 0;
    while (m_score < 8 && guard < 2000) begin
      ticks(1, 15);
      guard++;
    end
    checkOutput("boost_score", int'(score), 8);
    prev = lane(0);
    ticks(1, 3);
    checkOutput("boost_step4", lane(0), (prev + 4) % SCREEN_W);
    prev = lane(0);
    ticks(1, 15);
    checkOutput("boost_step15", lane(0), (prev + 15) % SCREEN_W);
`else
    guard = 0;
`endif

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
